midi_transmitter: RTL and testbench

- Serializes one MIDI message per handshake onto a single-wire MIDI OUT line: 31250 baud, 8N1 framing, LSB first, idle high.
- Bit timing matches the receiver: 128 CLK cycles per bit at 4 MHz.
- Upstream logic presents status plus up to two data bytes. The block derives the message length from the status byte and sends 1, 2 or 3 frames back-to-back.
- Sits between note/control generation logic and the MIDI OUT driver. It is the transmit end of the MIDI link.

---
 rtl/midi_pkg.sv | 39 +++
 rtl/midi_tx_frame.sv | 76 +++++++
 rtl/midi_transmitter.sv | 175 +++++++++++++++++
 tb/tb_midi_transmitter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : midi_pkg
// Purpose  : Shared MIDI transmit constants, FSM state type and length decode.
// Revision : 1.0 - initial release
// ============================================================================
package midi_pkg;

    localparam int MIDI_CLKS_PER_BIT = 128;
    localparam int MIDI_FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } midi_tx_state_t;

    // Number of bytes (status included) in a message introduced by this status.
    function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd1;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
            4'hC, 4'hD:                   len = 2'd2;
            4'hF: begin
                if (status[3:0] == 4'h2) begin
                    len = 2'd3;
                end else if ((status[3:0] == 4'h1) || (status[3:0] == 4'h3)) begin
                    len = 2'd2;
                end
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : midi_tx_frame
// Purpose  : Bit timer and 10-bit shifter emitting one 8N1 frame, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module midi_tx_frame
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       bit_done,
    output logic       frame_done
);

    localparam int            TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST   = 4'(MIDI_FRAME_BITS - 1);

    logic [TW-1:0] timer_q,   timer_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    shift_q,   shift_d;
    logic          active_q,  active_d;

    always_comb begin
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        active_d   = active_q;
        bit_done   = active_q && (timer_q == TIMER_LAST);
        frame_done = bit_done && (bit_idx_q == BIT_LAST);

        // A load on the final stop-bit cycle wins, so frames chain with no gap.
        if (load) begin
            timer_d   = '0;
            bit_idx_d = 4'd0;
            shift_d   = {1'b1, byte_in, 1'b0};
            active_d  = 1'b1;
        end else if (bit_done) begin
            timer_d = '0;
            shift_d = {1'b1, shift_q[9:1]};
            if (frame_done) begin
                active_d  = 1'b0;
                bit_idx_d = 4'd0;
            end else begin
                bit_idx_d = bit_idx_q + 4'd1;
            end
        end else if (active_q) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Idle shifter is all ones, which keeps the line high out of reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timer_q   <= '0;
            bit_idx_q <= 4'd0;
            shift_q   <= '1;
            active_q  <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            active_q  <= active_d;
        end
    end

    assign tx = shift_q[0];

endmodule
`default_nettype wire

// File: rtl/midi_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : midi_transmitter
// Purpose  : Accepts one MIDI message per handshake and sends 1-3 8N1 frames.
//            Define MIDI_RUNNING_STATUS_EN to omit repeated channel status.
// Revision : 1.0 - initial release
// ============================================================================
module midi_transmitter
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MSG_VALID,
    output logic       MSG_READY,
    input  logic [7:0] STATUS,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    output logic       TX,
    output logic       BUSY,
    output logic       MSG_ERR
);

    midi_tx_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q,    bit_cnt_d;
    logic [1:0]     bytes_left_q, bytes_left_d;
    logic [7:0]     next1_q,      next1_d;
    logic [7:0]     next2_q,      next2_d;
    logic           ready_en_q,   ready_en_d;
    logic           err_q,        err_d;

    logic           accept;
    logic           load;
    logic [7:0]     load_byte;
    logic [1:0]     msg_len;
    logic           skip_status;
    logic           bit_done;
    logic           frame_done;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]     run_status_q, run_status_d;
`endif

    assign MSG_READY = ready_en_q && (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign MSG_ERR   = err_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bytes_left_d = bytes_left_q;
        next1_d      = next1_q;
        next2_d      = next2_q;
        ready_en_d   = 1'b1;
        err_d        = 1'b0;
        load         = 1'b0;
        load_byte    = STATUS;
        accept       = MSG_VALID && MSG_READY;
        msg_len      = midi_msg_len(STATUS);
        skip_status  = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        run_status_d = run_status_q;
        // Stored status only ever holds a channel status or 00.
        if (STATUS[7:4] != 4'hF) begin
            skip_status = (STATUS == run_status_q);
        end
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!STATUS[7]) begin
                        err_d = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_d   = START;
                        bit_cnt_d = 3'd0;
                        next2_d   = DATA2 & 8'h7F;
                        if (skip_status) begin
                            load_byte    = DATA1 & 8'h7F;
                            next1_d      = DATA2 & 8'h7F;
                            bytes_left_d = msg_len - 2'd2;
                        end else begin
                            load_byte    = STATUS;
                            next1_d      = DATA1 & 8'h7F;
                            bytes_left_d = msg_len - 2'd1;
                        end
`ifdef MIDI_RUNNING_STATUS_EN
                        if (STATUS[7:4] != 4'hF) begin
                            run_status_d = STATUS;
                        end else if (!STATUS[3]) begin
                            run_status_d = 8'h00;
                        end
`endif
                    end
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = STOP;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (frame_done) begin
                    if (bytes_left_q != 2'd0) begin
                        load         = 1'b1;
                        load_byte    = next1_q;
                        next1_d      = next2_q;
                        bytes_left_d = bytes_left_q - 2'd1;
                        state_d      = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            bytes_left_q <= 2'd0;
            next1_q      <= 8'h00;
            next2_q      <= 8'h00;
            ready_en_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bytes_left_q <= bytes_left_d;
            next1_q      <= next1_d;
            next2_q      <= next2_d;
            ready_en_q   <= ready_en_d;
            err_q        <= err_d;
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            run_status_q <= 8'h00;
        end else begin
            run_status_q <= run_status_d;
        end
    end
`endif

    midi_tx_frame #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_frame (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (load),
        .byte_in   (load_byte),
        .tx        (TX),
        .bit_done  (bit_done),
        .frame_done(frame_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_midi_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_transmitter
// Purpose  : Randomized self-checking bench for midi_transmitter against a
//            per-cycle line waveform model built from the message rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_transmitter;

    localparam int CPB  = 128;
    localparam int MAXC = 4000;

    logic       CLK       = 1'b0;
    logic       RESET     = 1'b0;
    logic       MSG_VALID = 1'b0;
    logic [7:0] STATUS    = 8'h00;
    logic [7:0] DATA1     = 8'h00;
    logic [7:0] DATA2     = 8'h00;
    logic       MSG_READY;
    logic       TX;
    logic       BUSY;
    logic       MSG_ERR;

    int n_checks = 0;
    int n_pass   = 0;

    bit         obs_tx[$];
    bit         obs_busy[$];
    int         obs_ready_t;
    int         obs_err;
    logic [7:0] exp_bytes[$];
    int         exp_err;
    logic [7:0] model_rs = 8'h00;

    midi_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .MSG_VALID(MSG_VALID),
        .MSG_READY(MSG_READY),
        .STATUS   (STATUS),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .TX       (TX),
        .BUSY     (BUSY),
        .MSG_ERR  (MSG_ERR)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic int exp_len(input logic [7:0] s);
        if (s == 8'hF2) return 3;
        if (s == 8'hF1 || s == 8'hF3) return 2;
        if (s >= 8'hF0) return 1;
        if (s >= 8'hC0 && s < 8'hE0) return 2;
        return 3;
    endfunction

    task automatic model_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
        int n;
        bit send_status;
        exp_bytes.delete();
        exp_err = 0;
        if (s < 8'h80) begin
            exp_err = 1;
            return;
        end
        n = exp_len(s);
        send_status = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
        if (s < 8'hF0) begin
            if (s == model_rs) send_status = 1'b0;
            model_rs = s;
        end else if (s < 8'hF8) begin
            model_rs = 8'h00;
        end
`endif
        if (send_status) exp_bytes.push_back(s);
        if (n >= 2) exp_bytes.push_back(d1 % 8'd128);
        if (n == 3) exp_bytes.push_back(d2 % 8'd128);
    endtask

    function automatic int exp_cycles();
        return exp_bytes.size() * 10 * CPB;
    endfunction

    function automatic bit exp_tx(input int t);
        int fr, b;
        logic [7:0] v;
        if (t >= exp_cycles()) return 1'b1;
        fr = t / (10 * CPB);
        b  = (t / CPB) % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        v = exp_bytes[fr];
        return v[b-1];
    endfunction

    function automatic int tx_diffs();
        int d = 0;
        if (obs_tx.size() != exp_cycles() + 1) d++;
        for (int t = 0; t < obs_tx.size(); t++)
            if (obs_tx[t] !== exp_tx(t)) d++;
        return d;
    endfunction

    function automatic int busy_diffs();
        int d = 0;
        if (obs_busy.size() != exp_cycles() + 1) d++;
        for (int t = 0; t < obs_busy.size(); t++)
            if (obs_busy[t] !== (t < exp_cycles())) d++;
        return d;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic present(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
        MSG_VALID = 1'b1;
        STATUS    = s;
        DATA1     = d1;
        DATA2     = d2;
        @(negedge CLK);
    endtask

    task automatic scramble();
        MSG_VALID = 1'b0;
        STATUS    = 8'($urandom);
        DATA1     = 8'($urandom);
        DATA2     = 8'($urandom);
    endtask

    // Records line and busy per cycle from the cycle after acceptance until MSG_READY.
    task automatic capture();
        obs_tx.delete();
        obs_busy.delete();
        obs_ready_t = -1;
        obs_err     = 0;
        for (int t = 0; t < MAXC; t++) begin
            obs_tx.push_back(TX);
            obs_busy.push_back(BUSY);
            if (MSG_ERR) obs_err++;
            if (MSG_READY) begin
                obs_ready_t = t;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
        model_msg(s, d1, d2);
        present(s, d1, d2);
        scramble();
        capture();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad = 0;
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || BUSY !== 1'b0 || MSG_ERR !== 1'b0 || MSG_READY !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL reset_hold: %0d cycles with wrong outputs, required 0", bad);
        else n_pass++;
        RESET = 1'b1;
        model_rs = 8'h00;
        #1;
        n_checks++;
        if (MSG_READY !== 1'b0) $display("FAIL reset_release_ready: got %b, required 0", MSG_READY);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (MSG_READY !== 1'b1 || TX !== 1'b1) $display("FAIL ready_after_edge: ready=%b tx=%b, required 1/1", MSG_READY, TX);
        else n_pass++;
    endtask

    task automatic test_lengths();
        logic [7:0] tbl [3][3];
        int d;
        tbl[0] = '{8'h90, 8'h3C, 8'h64};
        tbl[1] = '{8'hC5, 8'h07, 8'($urandom)};
        tbl[2] = '{8'hF8, 8'($urandom), 8'($urandom)};
        for (int i = 0; i < 3; i++) begin
            send(tbl[i][0], tbl[i][1], tbl[i][2]);
            d = tx_diffs();
            n_checks++;
            if (d !== 0) $display("FAIL len_tx status=%02h: %0d cycles differ, required 0", tbl[i][0], d);
            else n_pass++;
            d = busy_diffs();
            n_checks++;
            if (d !== 0) $display("FAIL len_busy status=%02h: %0d cycles differ, required 0", tbl[i][0], d);
            else n_pass++;
            n_checks++;
            if (obs_ready_t !== exp_cycles()) $display("FAIL len_ready status=%02h: got %0d, required %0d", tbl[i][0], obs_ready_t, exp_cycles());
            else n_pass++;
            n_checks++;
            if (obs_err !== 0) $display("FAIL len_err status=%02h: got %0d pulses, required 0", tbl[i][0], obs_err);
            else n_pass++;
        end
    endtask

    task automatic test_reject();
        logic [7:0] s;
        int d;
        s = 8'h3C;
        send(s, 8'($urandom), 8'($urandom));
        n_checks++;
        if (obs_err !== exp_err) $display("FAIL reject_err: got %0d pulses, required %0d", obs_err, exp_err);
        else n_pass++;
        d = tx_diffs() + busy_diffs();
        n_checks++;
        if (d !== 0) $display("FAIL reject_line: %0d cycle differences, required 0", d);
        else n_pass++;
        n_checks++;
        if (obs_ready_t !== 0) $display("FAIL reject_ready: got %0d, required 0", obs_ready_t);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (MSG_ERR !== 1'b0 || MSG_READY !== 1'b1) $display("FAIL reject_pulse_len: err=%b ready=%b, required 0/1", MSG_ERR, MSG_READY);
        else n_pass++;
    endtask

    task automatic test_running_status();
        logic [7:0] tbl [4][3];
        int d;
        tbl[0] = '{8'h90, 8'h3C, 8'h64};
        tbl[1] = '{8'h90, 8'h3E, 8'h64};
        tbl[2] = '{8'hF2, 8'h01, 8'h02};
        tbl[3] = '{8'h90, 8'h40, 8'h7F};
        for (int i = 0; i < 4; i++) begin
            send(tbl[i][0], tbl[i][1], tbl[i][2]);
            d = tx_diffs() + busy_diffs();
            n_checks++;
            if (d !== 0) $display("FAIL rs_line msg%0d: %0d cycle differences, required 0", i, d);
            else n_pass++;
            n_checks++;
            if (obs_ready_t !== exp_cycles()) $display("FAIL rs_ready msg%0d: got %0d, required %0d", i, obs_ready_t, exp_cycles());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] s, d1, d2;
        int d;
        for (int i = 0; i < 6; i++) begin
            s  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            send(s, d1, d2);
            d = tx_diffs();
            n_checks++;
            if (d !== 0) $display("FAIL rand_tx status=%02h: %0d cycles differ, required 0", s, d);
            else n_pass++;
            d = busy_diffs();
            n_checks++;
            if (d !== 0) $display("FAIL rand_busy status=%02h: %0d cycles differ, required 0", s, d);
            else n_pass++;
            n_checks++;
            if (obs_ready_t !== exp_cycles()) $display("FAIL rand_ready status=%02h: got %0d, required %0d", s, obs_ready_t, exp_cycles());
            else n_pass++;
            n_checks++;
            if (obs_err !== exp_err) $display("FAIL rand_err status=%02h: got %0d, required %0d", s, obs_err, exp_err);
            else n_pass++;
            if (exp_err != 0) @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b_s, b_d1, b_d2;
        int d;
        b_s  = 8'hB0 | 8'($urandom_range(0, 15));
        b_d1 = 8'($urandom);
        b_d2 = 8'($urandom);
        model_msg(8'hE3, 8'h11, 8'h22);
        present(8'hE3, 8'h11, 8'h22);
        STATUS = b_s;
        DATA1  = b_d1;
        DATA2  = b_d2;
        capture();
        d = tx_diffs() + busy_diffs();
        n_checks++;
        if (d !== 0) $display("FAIL b2b_first_line: %0d cycle differences, required 0", d);
        else n_pass++;
        n_checks++;
        if (obs_ready_t !== exp_cycles()) $display("FAIL b2b_first_ready: got %0d, required %0d", obs_ready_t, exp_cycles());
        else n_pass++;
        model_msg(b_s, b_d1, b_d2);
        @(negedge CLK);
        scramble();
        capture();
        n_checks++;
        if (obs_tx[0] !== 1'b0) $display("FAIL b2b_gap: tx after one idle cycle got %b, required 0", obs_tx[0]);
        else n_pass++;
        d = tx_diffs() + busy_diffs();
        n_checks++;
        if (d !== 0) $display("FAIL b2b_second_line: %0d cycle differences, required 0", d);
        else n_pass++;
        n_checks++;
        if (obs_ready_t !== exp_cycles()) $display("FAIL b2b_second_ready: got %0d, required %0d", obs_ready_t, exp_cycles());
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int d;
        model_msg(8'h90, 8'h2C, 8'h64);
        present(8'h90, 8'h2C, 8'h64);
        scramble();
        repeat (15 * CPB + CPB / 2) @(negedge CLK);
        n_checks++;
        if (TX !== 1'b0) $display("FAIL midframe_bit4: tx got %b, required 0", TX);
        else n_pass++;
        RESET = 1'b0;
        #1;
        n_checks++;
        if (TX !== 1'b1 || BUSY !== 1'b0 || MSG_READY !== 1'b0) $display("FAIL midframe_async: tx=%b busy=%b ready=%b, required 1/0/0", TX, BUSY, MSG_READY);
        else n_pass++;
        @(negedge CLK);
        RESET    = 1'b1;
        model_rs = 8'h00;
        @(negedge CLK);
        n_checks++;
        if (MSG_READY !== 1'b1 || BUSY !== 1'b0 || TX !== 1'b1) $display("FAIL midframe_idle: ready=%b busy=%b tx=%b, required 1/0/1", MSG_READY, BUSY, TX);
        else n_pass++;
        send(8'h90, 8'($urandom), 8'($urandom));
        d = tx_diffs() + busy_diffs();
        n_checks++;
        if (d !== 0) $display("FAIL midframe_next_line: %0d cycle differences, required 0", d);
        else n_pass++;
        n_checks++;
        if (obs_ready_t !== exp_cycles()) $display("FAIL midframe_next_ready: got %0d, required %0d", obs_ready_t, exp_cycles());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lengths();
        test_reject();
        test_running_status();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
